// File: rtl/pop_scan_sequencer.sv
`timescale 1ns/1ps
// Ramsey/free-precession scan controller: steps fp_time per point, holds each point for a
// programmed number of POP cycles, and strobes each new value into the POP timer.
module pop_scan_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk_2M5,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] fp_start,
  input  logic [WIDTH-1:0] fp_step,
  input  logic [CNT_W-1:0] n_points,
  input  logic [CNT_W-1:0] cycles_per_point,
  input  logic             cycle_done,
  output logic [WIDTH-1:0] fp_time,
  output logic             fp_load,
  output logic [CNT_W-1:0] point_index,
  output logic             point_marker,
  output logic             busy,
  output logic             scan_done,
  output logic             sat
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_fp_step;
  logic [WIDTH-1:0] w_fp_step_nxt;
  logic [CNT_W-1:0] r_n_points;
  logic [CNT_W-1:0] w_n_points_nxt;
  logic [CNT_W-1:0] r_cpp;
  logic [CNT_W-1:0] w_cpp_nxt;
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] w_cyc_cnt_nxt;
  logic [WIDTH-1:0] r_fp_time;
  logic [WIDTH-1:0] w_fp_time_nxt;
  logic             r_fp_load;
  logic             w_fp_load_nxt;
  logic [CNT_W-1:0] r_point_index;
  logic [CNT_W-1:0] w_point_index_nxt;
  logic             r_point_marker;
  logic             w_point_marker_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_scan_done;
  logic             w_scan_done_nxt;
  logic             r_sat;
  logic             w_sat_nxt;

  logic             w_abort;
  logic [CNT_W-1:0] w_cpp_eff;
  logic [CNT_W:0]   w_cyc_inc;
  logic             w_last_cycle;
  logic             w_last_point;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_fp_sat;

  // Extended-width add so the carry out is visible for saturation.
  function automatic logic [WIDTH:0] add_ext(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  assign w_abort      = abort | ~enable;
  assign w_cpp_eff    = (r_cpp == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : r_cpp;
  assign w_cyc_inc    = {1'b0, r_cyc_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_last_cycle = (w_cyc_inc == {1'b0, w_cpp_eff});
  assign w_last_point = (({1'b0, r_point_index} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, r_n_points});
  assign w_sum        = add_ext(r_fp_time, r_fp_step);
  assign w_fp_sat     = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];

  // Next-state and next-output decode; abort/enable-low wins over everything outside IDLE.
  always_comb begin
    w_state_nxt        = r_state;
    w_fp_step_nxt      = r_fp_step;
    w_n_points_nxt     = r_n_points;
    w_cpp_nxt          = r_cpp;
    w_cyc_cnt_nxt      = r_cyc_cnt;
    w_fp_time_nxt      = r_fp_time;
    w_fp_load_nxt      = 1'b0;
    w_point_index_nxt  = r_point_index;
    w_point_marker_nxt = 1'b0;
    w_busy_nxt         = r_busy;
    w_scan_done_nxt    = 1'b0;
    w_sat_nxt          = r_sat;
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        if (start && !w_abort) begin
          if (n_points == '0) begin
            w_scan_done_nxt = 1'b1;
          end else begin
            w_fp_step_nxt     = fp_step;
            w_n_points_nxt    = n_points;
            w_cpp_nxt         = cycles_per_point;
            w_cyc_cnt_nxt     = '0;
            w_fp_time_nxt     = fp_start;
            w_fp_load_nxt     = 1'b1;
            w_point_index_nxt = '0;
            w_sat_nxt         = 1'b0;
            w_busy_nxt        = 1'b1;
            w_state_nxt       = S_ARM;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ARM: begin
        if (w_abort) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (cycle_done) begin
          // The cycle in flight at load time ran with stale timing and is not counted.
          w_cyc_cnt_nxt = '0;
          w_state_nxt   = S_RUN;
        end else begin
          w_state_nxt = S_ARM;
        end
      end
      S_RUN: begin
        if (w_abort) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (cycle_done) begin
          if (w_last_cycle) begin
            w_cyc_cnt_nxt = '0;
            w_state_nxt   = w_last_point ? S_DONE : S_STEP;
          end else begin
            w_cyc_cnt_nxt = w_cyc_inc[CNT_W-1:0];
          end
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_STEP: begin
        if (w_abort) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_fp_time_nxt      = w_fp_sat;
          w_sat_nxt          = r_sat | w_sum[WIDTH];
          w_point_index_nxt  = r_point_index + CNT_W'(1);
          w_fp_load_nxt      = 1'b1;
          w_point_marker_nxt = 1'b1;
          w_state_nxt        = S_ARM;
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
        if (w_abort) begin
          w_scan_done_nxt = 1'b0;
        end else begin
          w_scan_done_nxt = 1'b1;
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_2M5 or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_fp_step      <= '0;
      r_n_points     <= '0;
      r_cpp          <= '0;
      r_cyc_cnt      <= '0;
      r_fp_time      <= '0;
      r_fp_load      <= 1'b0;
      r_point_index  <= '0;
      r_point_marker <= 1'b0;
      r_busy         <= 1'b0;
      r_scan_done    <= 1'b0;
      r_sat          <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_fp_step      <= w_fp_step_nxt;
      r_n_points     <= w_n_points_nxt;
      r_cpp          <= w_cpp_nxt;
      r_cyc_cnt      <= w_cyc_cnt_nxt;
      r_fp_time      <= w_fp_time_nxt;
      r_fp_load      <= w_fp_load_nxt;
      r_point_index  <= w_point_index_nxt;
      r_point_marker <= w_point_marker_nxt;
      r_busy         <= w_busy_nxt;
      r_scan_done    <= w_scan_done_nxt;
      r_sat          <= w_sat_nxt;
    end
  end

  assign fp_time      = r_fp_time;
  assign fp_load      = r_fp_load;
  assign point_index  = r_point_index;
  assign point_marker = r_point_marker;
  assign busy         = r_busy;
  assign scan_done    = r_scan_done;
  assign sat          = r_sat;

endmodule

// File: tb/tb_pop_scan_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for pop_scan_sequencer: expected loads and completions are queued at start
// and consumed by a negedge monitor as the DUT produces them.
module tb_pop_scan_sequencer;

  logic        clk_2M5;
  logic        reset_n;
  logic        enable;
  logic        start;
  logic        abort;
  logic [15:0] fp_start;
  logic [15:0] fp_step;
  logic [15:0] n_points;
  logic [15:0] cycles_per_point;
  logic        cycle_done;
  logic [15:0] fp_time;
  logic        fp_load;
  logic [15:0] point_index;
  logic        point_marker;
  logic        busy;
  logic        scan_done;
  logic        sat;

  typedef struct {
    logic [15:0] fp;
    logic [15:0] idx;
  } load_t;

  load_t sb_load[$];
  logic  sb_done[$];
  int    n_checks;
  int    n_errors;
  int    n_loads;
  int    n_markers;
  int    n_dones;
  logic  m_sat;

  pop_scan_sequencer #(.WIDTH(16), .CNT_W(16)) dut (
    .clk_2M5(clk_2M5), .reset_n(reset_n), .enable(enable), .start(start), .abort(abort),
    .fp_start(fp_start), .fp_step(fp_step), .n_points(n_points),
    .cycles_per_point(cycles_per_point), .cycle_done(cycle_done),
    .fp_time(fp_time), .fp_load(fp_load), .point_index(point_index),
    .point_marker(point_marker), .busy(busy), .scan_done(scan_done), .sat(sat)
  );

  initial clk_2M5 = 1'b0;
  always #200 clk_2M5 = ~clk_2M5;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: consume scoreboard entries as load/done strobes appear.
  always @(negedge clk_2M5) begin
    if (reset_n) begin
      if (fp_load) begin
        n_loads++;
        if (sb_load.size() == 0) begin
          check_eq("load_unexpected", sb_load.size(), 1);
        end else begin
          load_t e;
          e = sb_load.pop_front();
          check_eq("load_fp_time", fp_time, e.fp);
          check_eq("load_point_index", point_index, e.idx);
        end
      end
      if (point_marker) n_markers++;
      if (scan_done) begin
        n_dones++;
        check_eq("done_busy", busy, 0);
        if (sb_done.size() == 0) begin
          check_eq("done_unexpected", sb_done.size(), 1);
        end else begin
          check_eq("done_sat", sat, sb_done.pop_front());
        end
      end
    end
  end

  task automatic flush_sb();
    sb_load.delete();
    sb_done.delete();
  endtask

  task automatic start_scan(input logic [15:0] fs, input logic [15:0] fst,
                            input logic [15:0] np, input logic [15:0] cpp);
    int v;
    @(negedge clk_2M5);
    fp_start = fs; fp_step = fst; n_points = np; cycles_per_point = cpp; start = 1'b1;
    if (np != 0) begin
      m_sat = 1'b0;
      v = fs;
      for (int i = 0; i < np; i++) begin
        load_t e;
        e.fp = v[15:0];
        e.idx = i[15:0];
        sb_load.push_back(e);
        if (i < np - 1) begin
          v = v + fst;
          if (v > 65535) begin
            v = 65535;
            m_sat = 1'b1;
          end
        end
      end
    end
    sb_done.push_back(m_sat);
    @(negedge clk_2M5);
    start = 1'b0;
    if (np != 0) begin
      check_eq("start_busy", busy, 1);
      check_eq("start_fp_load", fp_load, 1);
      check_eq("start_sat_clear", sat, 0);
    end
  endtask

  task automatic cd_pulse();
    repeat (9) begin
      @(negedge clk_2M5);
      cycle_done = 1'b0;
      start = 1'b0;
    end
    @(negedge clk_2M5);
    cycle_done = 1'b1;
  endtask

  task automatic run_scan(input logic [15:0] fs, input logic [15:0] fst, input logic [15:0] np,
                          input logic [15:0] cpp, input bit poke);
    int loads0, marks0, total, eff;
    loads0 = n_loads;
    marks0 = n_markers;
    start_scan(fs, fst, np, cpp);
    eff = (cpp == 0) ? 1 : int'(cpp);
    total = int'(np) * (eff + 1);
    for (int i = 0; i < total; i++) begin
      cd_pulse();
      if (poke && i == 1) begin
        start = 1'b1; fp_start = 16'd999; n_points = 16'd0;
      end
    end
    @(negedge clk_2M5);
    cycle_done = 1'b0;
    start = 1'b0;
    @(negedge clk_2M5);
    check_eq("scan_done_pulse", scan_done, 1);
    check_eq("scan_end_busy", busy, 0);
    @(negedge clk_2M5);
    #1;
    check_eq("scan_done_width", scan_done, 0);
    check_eq("scan_load_count", n_loads - loads0, np);
    check_eq("scan_marker_count", n_markers - marks0, np - 1);
    check_eq("scan_sb_empty", sb_load.size(), 0);
  endtask

  task automatic abort_scan(input bit use_enable);
    int loads0, dones0;
    loads0 = n_loads;
    dones0 = n_dones;
    start_scan(16'd10, 16'd5, 16'd4, 16'd2);
    repeat (5) cd_pulse();
    repeat (9) begin
      @(negedge clk_2M5);
      cycle_done = 1'b0;
    end
    @(negedge clk_2M5);
    cycle_done = 1'b1;
    if (use_enable) enable = 1'b0;
    else abort = 1'b1;
    @(negedge clk_2M5);
    cycle_done = 1'b0;
    abort = 1'b0;
    flush_sb();
    check_eq("abort_busy", busy, 0);
    check_eq("abort_point_index", point_index, 1);
    check_eq("abort_fp_load", fp_load, 0);
    check_eq("abort_marker", point_marker, 0);
    enable = 1'b1;
    repeat (20) @(negedge clk_2M5);
    #1;
    check_eq("abort_no_done", n_dones - dones0, 0);
    check_eq("abort_load_count", n_loads - loads0, 2);
    check_eq("abort_hold_index", point_index, 1);
    check_eq("abort_hold_fp", fp_time, 15);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; n_loads = 0; n_markers = 0; n_dones = 0; m_sat = 1'b0;
    reset_n = 1'b0; enable = 1'b1; start = 1'b0; abort = 1'b0; cycle_done = 1'b0;
    fp_start = 16'd0; fp_step = 16'd0; n_points = 16'd0; cycles_per_point = 16'd0;
    repeat (2) @(negedge clk_2M5);
    check_eq("reset_outputs", {fp_time, fp_load, point_index, point_marker, busy, scan_done, sat}, 0);
    reset_n = 1'b1;

    run_scan(16'd100, 16'd25, 16'd4, 16'd2, 1'b0);

    begin
      int loads0;
      loads0 = n_loads;
      start_scan(16'd5, 16'd5, 16'd0, 16'd3);
      check_eq("zero_done", scan_done, 1);
      check_eq("zero_busy", busy, 0);
      @(negedge clk_2M5);
      #1;
      check_eq("zero_done_width", scan_done, 0);
      check_eq("zero_busy_after", busy, 0);
      check_eq("zero_no_load", n_loads - loads0, 0);
    end

    run_scan(16'd40, 16'd3, 16'd2, 16'd0, 1'b0);

    run_scan(16'd65500, 16'd30, 16'd3, 16'd1, 1'b0);
    check_eq("sat_sticky", sat, 1);
    check_eq("sat_fp_final", fp_time, 65535);
    run_scan(16'd0, 16'd1, 16'd1, 16'd1, 1'b0);

    abort_scan(1'b0);
    abort_scan(1'b1);

    start_scan(16'd200, 16'd10, 16'd3, 16'd1);
    cd_pulse();
    @(negedge clk_2M5);
    cycle_done = 1'b0;
    repeat (2) @(negedge clk_2M5);
    check_eq("pre_reset_busy", busy, 1);
    #50;
    reset_n = 1'b0;
    #1;
    check_eq("midscan_reset", {fp_time, fp_load, point_index, point_marker, busy, scan_done, sat}, 0);
    flush_sb();
    m_sat = 1'b0;
    @(negedge clk_2M5);
    reset_n = 1'b1;
    run_scan(16'd300, 16'd7, 16'd3, 16'd2, 1'b1);

    repeat (3) @(negedge clk_2M5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pop_scan_sequencer.md
# pop_scan_sequencer

Autonomous Ramsey/free-precession scan controller for the POP timing core. While the POP-cycle mode is active, it steps the free-precession time from a programmed start value by a fixed increment, holds each value for a programmed number of complete POP cycles, and hands each new value to the POP timer block through a load strobe. It runs in the 2.5 MHz clock domain, alongside the button-driven manual adjustment path it replaces.

## Interface
- WIDTH, 16, width of free-precession time in 2.5 MHz ticks
- CNT_W, 16, width of point count and cycles-per-point count
- clk_2M5  in  1  2.5 MHz system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  scan permitted (high only in POP-cycle mode); low acts as abort
- start  in  1  single-cycle request to begin a scan
- abort  in  1  single-cycle request to stop the scan
- fp_start  in  WIDTH  first free-precession time
- fp_step  in  WIDTH  increment per point
- n_points  in  CNT_W  number of scan points
- cycles_per_point  in  CNT_W  complete POP cycles per point (0 is treated as 1)
- cycle_done  in  1  single-cycle pulse from the POP timer at the end of each POP cycle
- fp_time  out  WIDTH  free-precession time presented to the POP timer
- fp_load  out  1  single-cycle strobe: the POP timer adopts fp_time at its next cycle start
- point_index  out  CNT_W  current point, 0-based
- point_marker  out  1  single-cycle pulse on every point change after the first
- busy  out  1  scan in progress
- scan_done  out  1  single-cycle pulse on completion, including a zero-point start
- sat  out  1  sticky: fp_time saturated during the scan; cleared by the next accepted start

## Operation
- Reset values: fp_time=0, fp_load=0, point_index=0, point_marker=0, busy=0, scan_done=0, sat=0, state IDLE.
- fp_start, fp_step, n_points and cycles_per_point are latched on an accepted start. Input changes during a scan are ignored.
- IDLE: busy=0. A start with enable=1 is accepted.
  - If n_points=0: scan_done pulses, the state stays IDLE, and fp_load does not pulse.
  - Otherwise: fp_time<=fp_start, fp_load pulses, point_index<=0, sat<=0, busy<=1, and the state moves to ARM.
  - A start with enable=0 is ignored.
- ARM: wait for cycle_done. The POP cycle in flight when the load was issued used stale timing and is discarded. On cycle_done, the cycle counter is cleared and the state moves to RUN.
- RUN: each cycle_done increments the cycle counter. When the count reaches the effective cycles_per_point:
  - if point_index = n_points-1, move to DONE;
  - otherwise, move to STEP.
- STEP, which lasts one cycle:
  - fp_time <= fp_time + fp_step, computed at WIDTH+1 bits. On carry, fp_time saturates to 2^WIDTH-1 and sat is set.
  - point_index increments.
  - fp_load and point_marker pulse.
  - The state moves to ARM.
- DONE, which lasts one cycle: scan_done pulses, busy drops, and the state returns to IDLE. fp_time holds its last value.
- Abort, or enable going low, in any non-IDLE state returns the state to IDLE on the next edge, with busy=0. fp_time, point_index and sat hold their values. scan_done, fp_load and point_marker do not pulse.
- start while busy is ignored.

## Timing
- A start accepted at edge k makes busy=1 and fp_load=1 in the cycle after edge k. fp_time is valid in the same cycle as fp_load.
- cycle_done sampled at edge m in ARM puts the state in RUN after edge m. A cycle_done is not double-counted across the ARM to RUN transition.
- The final qualifying cycle_done at edge m puts STEP or DONE in the cycle after m. The resulting fp_load or point_marker pulse, or the scan_done pulse, is high for exactly one cycle, in the cycle after edge m+1.
- Abort or enable low beats a simultaneous cycle_done or start.
- Reset asserted mid-scan forces all outputs to their reset values immediately, without waiting for a clock edge.
- Total scan length is n_points × (cycles_per_point + 1) cycle_done pulses. The +1 is the discarded arm cycle per point.

## Test plan
- Basic scan: fp_start=100, fp_step=25, n_points=4, cycles_per_point=2, with cycle_done every 10 clocks.
  - Required: fp_load pulses 4 times with fp_time=100, 125, 150, 175.
  - Required: point_marker pulses 3 times.
  - Required: scan_done pulses once after the 12th cycle_done; busy then reads 0.
- Saturation: WIDTH=16, fp_start=65500, fp_step=30, n_points=3.
  - Required: fp_time reads 65500, then 65530, then 65535, and sat=1 at completion.
  - Required: a new start clears sat.
- Zero and degenerate configuration:
  - n_points=0: scan_done pulses in the cycle after start, with busy=0 throughout and no fp_load.
  - cycles_per_point=0: each point lasts 2 cycle_done pulses.
- Abort: abort coincident with the 3rd cycle_done of point 1.
  - Required: IDLE on the next edge with busy=0, point_index=1, and no scan_done.
  - Required: dropping enable mid-scan gives the same result.
- Reset and restart:
  - Asserting reset_n low between edges in RUN forces all outputs to 0 at once.
  - After release, a start with enable=1 runs a full scan correctly.
  - start pulses while busy have no effect on point_index or fp_time.
